spy_path_meas_ctrl: RTL and testbench

- Sequences timing measurements on one chained spy delay path. The path is combinational, for example 50 non-inverting-pair stages, with input pathInput and output pathResult.
- Launches alternating edges into the path and samples the path output a programmable number of clocks later. Compares each sample against the expected settled level.
- Accumulates pass/fail counts over a programmed number of trials. Sits between the host register interface and the path instance.

---
 rtl/spy_meas_pkg.sv | 21 ++
 rtl/spy_sat_counter.sv | 37 +++
 rtl/spy_path_meas_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_spy_path_meas_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spy_meas_pkg.sv
// Shared types and helpers for the spy delay-path measurement controller.
package spy_meas_pkg;

    localparam int unsigned SPY_DLY_W   = 8;
    localparam int unsigned SPY_TRIAL_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StCheck,
        StSettle,
        StDone
    } meas_state_e;

    // Widths up to 32 bits; callers zero-extend and truncate around the call.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/spy_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the pass and fail tallies.
module spy_sat_counter
    import spy_meas_pkg::*;
#(
    parameter int unsigned TRIAL_W = SPY_TRIAL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               inc_i,
    output logic [TRIAL_W-1:0] count_o
);

    localparam logic [TRIAL_W-1:0] CntMax = '1;

    logic [TRIAL_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = TRIAL_W'(sat_inc(32'(count_q), 32'(CntMax)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spy_path_meas_ctrl.sv
// Launch/capture sequencer for one spy delay path with pass/fail tallies.
// Define SPY_FIRST_FAIL_EN to add first_fail_idx/first_fail_vld reporting.
module spy_path_meas_ctrl
    import spy_meas_pkg::*;
#(
    parameter int unsigned DLY_W     = SPY_DLY_W,
    parameter int unsigned TRIAL_W   = SPY_TRIAL_W,
    parameter int unsigned SETTLE    = 4,
    parameter bit          INVERTING = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DLY_W-1:0]   sample_delay,
    input  logic [TRIAL_W-1:0] num_trials,
    output logic               path_launch,
    input  logic               path_capture,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [TRIAL_W-1:0] pass_cnt,
    output logic [TRIAL_W-1:0] fail_cnt
`ifdef SPY_FIRST_FAIL_EN
    ,
    output logic [TRIAL_W-1:0] first_fail_idx,
    output logic               first_fail_vld
`endif
);

    // Settle count reaches D + SETTLE - 1 with D up to 2**DLY_W - 1.
    localparam int unsigned SetMax = (1 << DLY_W) + SETTLE - 2;
    localparam int unsigned SetW   = (SetMax < 2) ? 1 : $clog2(SetMax + 1);

    meas_state_e        state_d, state_q;
    logic               launch_d, launch_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic               aborted_d, aborted_q;
    logic               cap_d, cap_q;
    logic [DLY_W-1:0]   delay_d, delay_q;
    logic [DLY_W-1:0]   dly_cnt_d, dly_cnt_q;
    logic [SetW-1:0]    settle_cnt_d, settle_cnt_q;
    logic [TRIAL_W-1:0] trials_d, trials_q;
    logic [TRIAL_W-1:0] trial_idx_d, trial_idx_q;

    logic start_acc;
    logic check_now;
    logic match;

    assign start_acc = (state_q == StIdle) && start;
    assign check_now = (state_q == StCheck);
    assign match     = (cap_q == (launch_q ^ INVERTING));

    always_comb begin
        state_d      = state_q;
        launch_d     = launch_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        delay_d      = delay_q;
        dly_cnt_d    = dly_cnt_q;
        settle_cnt_d = settle_cnt_q;
        trials_d     = trials_q;
        trial_idx_d  = trial_idx_q;
        cap_d        = cap_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    delay_d     = (sample_delay == '0) ? DLY_W'(1) : sample_delay;
                    trials_d    = num_trials;
                    trial_idx_d = '0;
                    busy_d      = 1'b1;
                    aborted_d   = 1'b0;
                    state_d     = (num_trials == '0) ? StDone : StLaunch;
                end
            end
            StLaunch: begin
                launch_d  = ~launch_q;
                dly_cnt_d = delay_q - DLY_W'(1);
                state_d   = StWait;
            end
            StWait: begin
                if (dly_cnt_q == '0) begin
                    cap_d   = path_capture;
                    state_d = StCheck;
                end else begin
                    dly_cnt_d = dly_cnt_q - DLY_W'(1);
                end
            end
            StCheck: begin
                trial_idx_d  = trial_idx_q + TRIAL_W'(1);
                settle_cnt_d = SetW'(delay_q) + SetW'(SETTLE) - SetW'(1);
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == '0) begin
                    state_d = (trial_idx_q < trials_q) ? StLaunch : StDone;
                end else begin
                    settle_cnt_d = settle_cnt_q - SetW'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything except the tally of a CHECK in the same cycle.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            launch_d  = launch_q;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            launch_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            cap_q        <= 1'b0;
            delay_q      <= '0;
            dly_cnt_q    <= '0;
            settle_cnt_q <= '0;
            trials_q     <= '0;
            trial_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            launch_q     <= launch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            cap_q        <= cap_d;
            delay_q      <= delay_d;
            dly_cnt_q    <= dly_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            trials_q     <= trials_d;
            trial_idx_q  <= trial_idx_d;
        end
    end

    spy_sat_counter #(.TRIAL_W(TRIAL_W)) u_pass_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_acc),
        .inc_i   (check_now && match),
        .count_o (pass_cnt)
    );

    spy_sat_counter #(.TRIAL_W(TRIAL_W)) u_fail_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_acc),
        .inc_i   (check_now && !match),
        .count_o (fail_cnt)
    );

`ifdef SPY_FIRST_FAIL_EN
    logic [TRIAL_W-1:0] ff_idx_d, ff_idx_q;
    logic               ff_vld_d, ff_vld_q;

    always_comb begin
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
        if (start_acc) begin
            ff_idx_d = '0;
            ff_vld_d = 1'b0;
        end else if (check_now && !match && !ff_vld_q) begin
            ff_idx_d = trial_idx_q;
            ff_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
        end else begin
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_vld = ff_vld_q;
`endif

    assign path_launch = launch_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_spy_path_meas_ctrl.sv
// Directed bench for spy_path_meas_ctrl; the path is modelled as a pure delay of P clocks.
module tb_spy_path_meas_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  sample_delay;
    logic [15:0] num_trials;
    logic        path_launch;
    logic        path_capture;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
`ifdef SPY_FIRST_FAIL_EN
    logic [15:0] first_fail_idx;
    logic        first_fail_vld;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Path model: history of path_launch, tap selected by P.
    logic [15:0] hist = '0;
    logic [3:0]  p_fix = 4'd0;
    logic        alt = 1'b0;
    logic        alt_base = 1'b0;
    logic [3:0]  p_eff;

    spy_path_meas_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .sample_delay (sample_delay),
        .num_trials   (num_trials),
        .path_launch  (path_launch),
        .path_capture (path_capture),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
`ifdef SPY_FIRST_FAIL_EN
        ,
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) hist <= {hist[14:0], path_launch};

    // Alternating model: odd-numbered launches of a run (level != base) see P=1, even ones P=9.
    always_comb p_eff = alt ? ((path_launch != alt_base) ? 4'd1 : 4'd9) : p_fix;
    always_comb path_capture = (p_eff == 4'd0) ? path_launch : hist[p_eff - 4'd1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] d, input logic [15:0] n);
        sample_delay = d;
        num_trials   = n;
        start        = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles are counted in ticks from the one whose edge accepts start (tick 1).
    task automatic wait_done(input string tag, input int exp_cyc, input int start_cyc);
        int cyc;
        bit seen;
        cyc  = start_cyc;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            tick();
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        sample_delay = '0;
        num_trials   = '0;
        #12;
        chk("rst_launch",  32'(path_launch), 0);
        chk("rst_busy",    32'(busy),        0);
        chk("rst_done",    32'(done),        0);
        chk("rst_aborted", 32'(aborted),     0);
        chk("rst_pass",    32'(pass_cnt),    0);
        chk("rst_fail",    32'(fail_cnt),    0);
        tick();
        rst = 1'b0;
        tick();

        // A: P=3, D=5, 4 trials -> all pass; 4 x 16 cycles + DONE + registered pulse.
        p_fix = 4'd3;
        start_run(8'd5, 16'd4);
        chk("a_busy", 32'(busy), 1);
        chk("a_launch_pre", 32'(path_launch), 0);
        wait_done("a_done_cycle", 66, 1);
        chk("a_pass", 32'(pass_cnt), 4);
        chk("a_fail", 32'(fail_cnt), 0);
        chk("a_busy_end", 32'(busy), 0);
        tick();
        chk("a_done_pulse", 32'(done), 0);
        chk("a_launch_end", 32'(path_launch), 0);

        // B: P=3, D=2, 6 trials -> stale samples; start held while busy is ignored.
        sample_delay = 8'd2;
        num_trials   = 16'd6;
        start        = 1'b1;
        tick();
        num_trials   = 16'd1;
        sample_delay = 8'd9;
        tick();
        tick();
        start = 1'b0;
        wait_done("b_done_cycle", 62, 3);
        chk("b_pass", 32'(pass_cnt), 0);
        chk("b_fail", 32'(fail_cnt), 6);

        // C: D=0 (treated as 1), P=0, 1 trial -> capture one clock after launch.
        tick();
        p_fix = 4'd0;
        start_run(8'd0, 16'd1);
        chk("c_launch_pre", 32'(path_launch), 0);
        tick();
        chk("c_launch_rise", 32'(path_launch), 1);
        wait_done("c_done_cycle", 10, 2);
        chk("c_pass", 32'(pass_cnt), 1);
        chk("c_fail", 32'(fail_cnt), 0);

        // D: zero trials -> done two cycles after start, counts cleared.
        tick();
        start_run(8'd5, 16'd0);
        chk("d_busy", 32'(busy), 1);
        wait_done("d_done_cycle", 2, 1);
        chk("d_pass", 32'(pass_cnt), 0);
        chk("d_launch", 32'(path_launch), 1);
        tick();
        chk("d_done_pulse", 32'(done), 0);

        // E: start+abort together (start wins), then abort in WAIT of trial 2 of 5.
        p_fix = 4'd3;
        abort = 1'b1;
        start_run(8'd5, 16'd5);
        abort = 1'b0;
        chk("e_start_wins_busy", 32'(busy), 1);
        chk("e_start_wins_abt", 32'(aborted), 0);
        repeat (34) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("e_busy", 32'(busy), 0);
        chk("e_aborted", 32'(aborted), 1);
        chk("e_pass", 32'(pass_cnt), 2);
        chk("e_fail", 32'(fail_cnt), 0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        chk("e_no_done", 32'(seen_done), 0);
        chk("e_launch_hold", 32'(path_launch), 0);
        chk("e_pass_frozen", 32'(pass_cnt), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("e_idle_abort_busy", 32'(busy), 0);
        chk("e_idle_abort_sticky", 32'(aborted), 1);

        // F: async reset in SETTLE of trial 0, then a normal run.
        start_run(8'd5, 16'd4);
        chk("f_aborted_clr", 32'(aborted), 0);
        repeat (10) tick();
        chk("f_pass_pre", 32'(pass_cnt), 1);
        chk("f_launch_pre", 32'(path_launch), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("f_rst_launch", 32'(path_launch), 0);
        chk("f_rst_busy",   32'(busy),        0);
        chk("f_rst_pass",   32'(pass_cnt),    0);
        chk("f_rst_done",   32'(done),        0);
        chk("f_rst_abt",    32'(aborted),     0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        start_run(8'd5, 16'd1);
        chk("f_launch_low", 32'(path_launch), 0);
        tick();
        chk("f_launch_rise", 32'(path_launch), 1);
        wait_done("f_done_cycle", 18, 2);
        chk("f_pass", 32'(pass_cnt), 1);

        // G: delay alternates P=1/P=9 per trial, D=5, 4 trials -> trials 1 and 3 fail.
        tick();
        alt_base = path_launch;
        alt      = 1'b1;
        start_run(8'd5, 16'd4);
`ifdef SPY_FIRST_FAIL_EN
        chk("g_vld_clr", 32'(first_fail_vld), 0);
`endif
        wait_done("g_done_cycle", 66, 1);
        chk("g_pass", 32'(pass_cnt), 2);
        chk("g_fail", 32'(fail_cnt), 2);
`ifdef SPY_FIRST_FAIL_EN
        chk("g_ff_idx", 32'(first_fail_idx), 1);
        chk("g_ff_vld", 32'(first_fail_vld), 1);
`endif
        alt = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
